// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit path.
// UART_PARITY_EN adds the PARITY state to the encoding.
package uart_pkg;

    localparam int DATA_BITS_DEF = 8;
    localparam int STOP_BITS_DEF = 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARM    = 3'd1,
        ST_START  = 3'd2,
        ST_DATA   = 3'd3,
`ifdef UART_PARITY_EN
        ST_PARITY = 3'd4,
`endif
        ST_STOP   = 3'd5
    } tx_state_t;

endpackage

// File: rtl/baud_edge_det.sv
// Two-flop synchroniser plus registered rising-edge detector for the baud clock.
// rise_pulse is a one-cycle pulse three clock edges after sig_in rises.
module baud_edge_det (
    input  logic clock,
    input  logic rst,
    input  logic sig_in,
    output logic rise_pulse
);

    logic       sync_1;
    logic       sync_2;
    logic       sync_3;
    logic [2:0] fill;

    // fill gates the detector until sync_3 holds a real sample, so a line
    // that is already high when reset drops is not mistaken for an edge
    always_ff @(posedge clock) begin
        if (rst) begin
            sync_1     <= 1'b0;
            sync_2     <= 1'b0;
            sync_3     <= 1'b0;
            fill       <= 3'b000;
            rise_pulse <= 1'b0;
        end else begin
            sync_1     <= sig_in;
            sync_2     <= sync_1;
            sync_3     <= sync_2;
            fill       <= {fill[1:0], 1'b1};
            rise_pulse <= fill[2] & sync_2 & ~sync_3;
        end
    end

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit framer: start bit, DATA_BITS data bits LSB first, optional parity, STOP_BITS stop bits.
// Build option: define UART_PARITY_EN to insert the parity bit (sense set by PARITY_ODD).
//
// state  | meaning
// IDLE   | line high, ready for a word
// ARM    | word latched, waiting for the next baud tick
// START  | driving the start bit
// DATA   | driving data bits, LSB first
// PARITY | driving the parity bit (UART_PARITY_EN only)
// STOP   | driving the stop bit(s)
module uart_tx_framer
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = DATA_BITS_DEF,
    parameter int STOP_BITS  = STOP_BITS_DEF,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clock,
    input  logic                 rst,
    input  logic                 baud_clk,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 txd,
    output logic                 tx_busy
);

    localparam int BIT_CNT_W  = $clog2(DATA_BITS);
    localparam int STOP_CNT_W = (STOP_BITS > 1) ? $clog2(STOP_BITS) : 1;

    generate
        if (DATA_BITS < 5 || DATA_BITS > 8 || (STOP_BITS != 1 && STOP_BITS != 2) ||
            (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_param_check
            $error("uart_tx_framer: illegal parameter setting");
        end
    endgenerate

    tx_state_t              state;
    logic [DATA_BITS-1:0]   shreg;
    logic [BIT_CNT_W-1:0]   bit_cnt;
    logic [STOP_CNT_W-1:0]  stop_cnt;
    logic                   baud_tick;
`ifdef UART_PARITY_EN
    logic                   parity_bit;
`endif

    baud_edge_det u_baud_edge_det (
        .clock      (clock),
        .rst        (rst),
        .sig_in     (baud_clk),
        .rise_pulse (baud_tick)
    );

    // bit_cnt and stop_cnt count the bits still to follow the one on the line
    always_ff @(posedge clock) begin
        if (rst) begin
            state      <= ST_IDLE;
            txd        <= 1'b1;
            tx_ready   <= 1'b1;
            tx_busy    <= 1'b0;
            shreg      <= '0;
            bit_cnt    <= '0;
            stop_cnt   <= '0;
`ifdef UART_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (tx_valid && tx_ready) begin
                        shreg      <= tx_data;
`ifdef UART_PARITY_EN
                        parity_bit <= (^tx_data) ^ 1'(PARITY_ODD);
`endif
                        state      <= ST_ARM;
                        tx_ready   <= 1'b0;
                        tx_busy    <= 1'b1;
                    end
                end
                ST_ARM: begin
                    if (baud_tick) begin
                        state <= ST_START;
                        txd   <= 1'b0;
                    end
                end
                ST_START: begin
                    if (baud_tick) begin
                        state   <= ST_DATA;
                        txd     <= shreg[0];
                        shreg   <= shreg >> 1;
                        bit_cnt <= BIT_CNT_W'(DATA_BITS - 1);
                    end
                end
                ST_DATA: begin
                    if (baud_tick) begin
                        if (bit_cnt == '0) begin
`ifdef UART_PARITY_EN
                            state    <= ST_PARITY;
                            txd      <= parity_bit;
`else
                            state    <= ST_STOP;
                            txd      <= 1'b1;
                            stop_cnt <= STOP_CNT_W'(STOP_BITS - 1);
`endif
                        end else begin
                            txd     <= shreg[0];
                            shreg   <= shreg >> 1;
                            bit_cnt <= bit_cnt - 1'b1;
                        end
                    end
                end
`ifdef UART_PARITY_EN
                ST_PARITY: begin
                    if (baud_tick) begin
                        state    <= ST_STOP;
                        txd      <= 1'b1;
                        stop_cnt <= STOP_CNT_W'(STOP_BITS - 1);
                    end
                end
`endif
                ST_STOP: begin
                    if (baud_tick) begin
                        if (stop_cnt == '0) begin
                            state    <= ST_IDLE;
                            tx_ready <= 1'b1;
                            tx_busy  <= 1'b0;
                        end else begin
                            stop_cnt <= stop_cnt - 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    txd      <= 1'b1;
                    tx_ready <= 1'b1;
                    tx_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed bench for uart_tx_framer: 8N1 and 8N2 instances, plus an odd-parity
// instance when UART_PARITY_EN is defined. Line is sampled mid-bit on baud_clk falls.
module tb_uart_tx_framer;

`ifdef UART_PARITY_EN
    localparam int NDUT = 3;
`else
    localparam int NDUT = 2;
`endif

    logic       clock = 1'b0;
    logic       rst = 1'b1;
    logic       baud_clk = 1'b0;
    bit         baud_run = 1'b1;
    int         bcnt = 0;

    logic [7:0] tx_data  [NDUT];
    logic       tx_valid [NDUT];
    logic       ready_o  [NDUT];
    logic       txd_o    [NDUT];
    logic       busy_o   [NDUT];

    int n_tests = 0;
    int n_fail  = 0;

    uart_tx_framer #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) dut_a (
        .clock(clock), .rst(rst), .baud_clk(baud_clk),
        .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
        .tx_ready(ready_o[0]), .txd(txd_o[0]), .tx_busy(busy_o[0])
    );

    uart_tx_framer #(.DATA_BITS(8), .STOP_BITS(2), .PARITY_ODD(0)) dut_b (
        .clock(clock), .rst(rst), .baud_clk(baud_clk),
        .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
        .tx_ready(ready_o[1]), .txd(txd_o[1]), .tx_busy(busy_o[1])
    );

`ifdef UART_PARITY_EN
    uart_tx_framer #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(1)) dut_c (
        .clock(clock), .rst(rst), .baud_clk(baud_clk),
        .tx_data(tx_data[2]), .tx_valid(tx_valid[2]),
        .tx_ready(ready_o[2]), .txd(txd_o[2]), .tx_busy(busy_o[2])
    );
`endif

    always #5 clock = ~clock;

    // baud_clk: 16 clock cycles per period, can be frozen via baud_run
    always @(negedge clock) begin
        if (baud_run) begin
            bcnt = bcnt + 1;
            if (bcnt == 8) begin
                bcnt = 0;
                baud_clk = ~baud_clk;
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input int sel, input logic [7:0] d);
        @(negedge baud_clk);
        @(negedge clock);
        tx_valid[sel] = 1'b1;
        tx_data[sel]  = d;
        @(posedge clock);
        #1;
        check_val($sformatf("accept dut%0d", sel), 32'(ready_o[sel]), 32'd0);
        @(negedge clock);
        tx_valid[sel] = 1'b0;
    endtask

    task automatic check_frame(input string tag, input int sel, input logic [7:0] d,
                               input int nstop, input bit par_odd);
        logic exp_bits[$];
        exp_bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_bits.push_back(d[i]);
`ifdef UART_PARITY_EN
        exp_bits.push_back((^d) ^ par_odd);
`endif
        for (int i = 0; i < nstop; i++) exp_bits.push_back(1'b1);
        for (int k = 0; k < exp_bits.size(); k++) begin
            @(negedge baud_clk);
            check_val($sformatf("%s bit%0d", tag, k), 32'(txd_o[sel]), 32'(exp_bits[k]));
            check_val($sformatf("%s busy%0d", tag, k), 32'(busy_o[sel]), 32'd1);
        end
    endtask

    task automatic check_idle(input string tag, input int sel);
        @(negedge baud_clk);
        check_val({tag, " ready"}, 32'(ready_o[sel]), 32'd1);
        check_val({tag, " txd"}, 32'(txd_o[sel]), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected run to complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int lows;
        for (int i = 0; i < NDUT; i++) begin
            tx_valid[i] = 1'b0;
            tx_data[i]  = 8'h00;
        end

        // reset state
        repeat (3) @(negedge clock);
        check_val("reset txd", 32'(txd_o[0]), 32'd1);
        check_val("reset ready", 32'(ready_o[0]), 32'd1);
        check_val("reset busy", 32'(busy_o[0]), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge baud_clk);
        check_val("post-reset idle txd", 32'(txd_o[0]), 32'd1);
        check_val("post-reset idle ready", 32'(ready_o[0]), 32'd1);

        // 8N1 0x55
        send(0, 8'h55);
        check_frame("8n1_55", 0, 8'h55, 1, 1'b0);
        check_idle("8n1_55 end", 0);

        // acceptance coincides with a baud tick: ARM must wait one more tick
        @(posedge baud_clk);
        repeat (3) @(negedge clock);
        tx_valid[0] = 1'b1;
        tx_data[0]  = 8'h3C;
        @(posedge clock);
        #1;
        check_val("tick-accept ready", 32'(ready_o[0]), 32'd0);
        @(negedge clock);
        tx_valid[0] = 1'b0;
        @(negedge baud_clk);
        check_val("tick-accept arm hold txd", 32'(txd_o[0]), 32'd1);
        check_frame("tick_3c", 0, 8'h3C, 1, 1'b0);
        check_idle("tick_3c end", 0);

        // back-to-back with tx_valid held high
        @(negedge baud_clk);
        @(negedge clock);
        tx_valid[0] = 1'b1;
        tx_data[0]  = 8'hA3;
        @(posedge clock);
        #1;
        check_val("b2b accept a3", 32'(ready_o[0]), 32'd0);
        @(negedge clock);
        tx_data[0] = 8'h0F;
        check_frame("b2b_a3", 0, 8'hA3, 1, 1'b0);
        w = 0;
        while (ready_o[0] !== 1'b1 && w < 64) begin
            @(posedge clock);
            #1;
            w++;
        end
        check_val("b2b idle reached", 32'(ready_o[0]), 32'd1);
        @(posedge clock);
        #1;
        check_val("b2b accept after 1 idle cycle", 32'(ready_o[0]), 32'd0);
        @(negedge clock);
        tx_valid[0] = 1'b0;
        @(negedge baud_clk);
        check_val("b2b arm gap txd", 32'(txd_o[0]), 32'd1);
        check_frame("b2b_0f", 0, 8'h0F, 1, 1'b0);
        check_idle("b2b_0f end", 0);

        // reset in the middle of data bit 4
        send(0, 8'h00);
        repeat (5) @(negedge baud_clk);
        @(posedge baud_clk);
        repeat (6) @(negedge clock);
        check_val("pre-reset bit4", 32'(txd_o[0]), 32'd0);
        rst = 1'b1;
        @(posedge clock);
        #1;
        check_val("abort txd", 32'(txd_o[0]), 32'd1);
        check_val("abort ready", 32'(ready_o[0]), 32'd1);
        check_val("abort busy", 32'(busy_o[0]), 32'd0);
        @(negedge clock);
        rst = 1'b0;
        lows = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge baud_clk);
            if (txd_o[0] !== 1'b1) lows++;
        end
        check_val("abort no further bits", 32'(lows), 32'd0);
        check_val("abort stays ready", 32'(ready_o[0]), 32'd1);

        // 8N2 0x00
        send(1, 8'h00);
        check_frame("8n2_00", 1, 8'h00, 2, 1'b0);
        check_val("8n2 busy in 2nd stop", 32'(ready_o[1]), 32'd0);
        check_idle("8n2_00 end", 1);

        // baud_clk frozen after acceptance: stays in ARM
        @(negedge baud_clk);
        baud_run = 1'b0;
        @(negedge clock);
        tx_valid[0] = 1'b1;
        tx_data[0]  = 8'h81;
        @(posedge clock);
        #1;
        check_val("static accept", 32'(ready_o[0]), 32'd0);
        @(negedge clock);
        tx_valid[0] = 1'b0;
        repeat (100) @(posedge clock);
        #1;
        check_val("static arm txd", 32'(txd_o[0]), 32'd1);
        check_val("static arm busy", 32'(busy_o[0]), 32'd1);
        baud_run = 1'b1;
        check_frame("static_81", 0, 8'h81, 1, 1'b0);
        check_idle("static_81 end", 0);

`ifdef UART_PARITY_EN
        // parity of 0x07: even sense -> 1, odd sense -> 0
        send(0, 8'h07);
        check_frame("even_07", 0, 8'h07, 1, 1'b0);
        check_idle("even_07 end", 0);
        send(2, 8'h07);
        check_frame("odd_07", 2, 8'h07, 1, 1'b1);
        check_idle("odd_07 end", 2);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_framer.md
UART_TX_FRAMER -- requirements
Module: uart_tx_framer

Interface
REQ-001 Parameter DATA_BITS, default 8, number of data bits per frame, legal range 5..8.
REQ-002 Parameter STOP_BITS, default 1, number of stop bits per frame, legal values 1 or 2.
REQ-003 Parameter PARITY_ODD, default 0, parity sense: 0 selects even parity, 1 selects odd; used only when UART_PARITY_EN is defined.
REQ-004 Port clock, input, 1 bit, the single system clock; all state SHALL change on its rising edge.
REQ-005 Port rst, input, 1 bit, synchronous active-high reset.
REQ-006 Port baud_clk, input, 1 bit, baud-rate clock from the half-integer divider; sampled as data, never used as a clock.
REQ-007 Port tx_data, input, DATA_BITS bits, byte to transmit.
REQ-008 Port tx_valid, input, 1 bit, tx_data is valid.
REQ-009 Port tx_ready, output, 1 bit, the block can accept a new word.
REQ-010 Port txd, output, 1 bit, serial line, idle high.
REQ-011 Port tx_busy, output, 1 bit, a frame is pending or in progress.

Function
REQ-012 baud_clk SHALL pass through a 2-flop synchroniser and a rising-edge detector to produce a one-cycle baud_tick, 3 clock cycles after the baud_clk rising edge.
REQ-013 The FSM states SHALL be IDLE, ARM, START, DATA, PARITY and STOP.
REQ-014 tx_ready SHALL be 1 only in IDLE, and tx_busy SHALL equal NOT tx_ready.
REQ-015 On tx_valid AND tx_ready, the FSM SHALL latch tx_data into a shift register and move to ARM; tx_valid SHALL be ignored in every other state.
REQ-016 ARM + baud_tick: move to START and drive txd=0.
REQ-017 START + baud_tick: move to DATA and drive data bit 0 (LSB first).
REQ-018 DATA + baud_tick: drive the next bit; after DATA_BITS bits, go to PARITY if enabled, else to STOP with txd=1.
REQ-019 PARITY + baud_tick: move to STOP and drive txd=1.
REQ-020 STOP SHALL hold txd=1 for STOP_BITS ticks, then return to IDLE; the frame occupies 1+DATA_BITS+P+STOP_BITS ticks, with P=1 when parity is enabled.
REQ-021 Back-to-back: a word held on tx_valid SHALL be accepted in the first IDLE cycle after STOP completes.
REQ-022 txd SHALL be registered with no combinational path from any input, and bit and stop counters SHALL be sized for their maximum value with no wrap-around.
REQ-023 A baud_tick that arrives in the same cycle as acceptance SHALL NOT advance ARM; the start bit begins on the next tick.

Reset
REQ-024 While rst=1 at a clock edge: state=IDLE, txd=1, tx_ready=1, tx_busy=0, synchroniser flops=0, and counters and shift register=0.
REQ-025 A reset mid-frame SHALL abort the frame, return txd to 1 on the next edge, and discard the latched word.
REQ-026 After reset the edge detector SHALL NOT report a tick unless baud_clk actually rises.

Configuration
REQ-027 Macro UART_PARITY_EN: when defined, the PARITY state is present and emits the XOR of the data bits, XOR PARITY_ODD.
REQ-028 When UART_PARITY_EN is undefined, the PARITY state and the parity logic SHALL be absent and DATA SHALL go straight to STOP.

Structure
REQ-029 A shared package uart_pkg SHALL hold the FSM state encoding typedef and the defaults for DATA_BITS and STOP_BITS.
REQ-030 The synchroniser plus edge detector SHALL be a sub-module named baud_edge_det (ports clock, rst, sig_in, rise_pulse).
REQ-031 The top level SHALL contain the FSM, the shift register and the counters only.

Verification
REQ-032 8N1, baud_clk period 16 cycles, tx_data=0x55: txd = 0,1,0,1,0,1,0,1,0,1 per tick, then IDLE with tx_ready=1 after 10 ticks.
REQ-033 tx_valid held high with 0xA3 then 0x0F: second word accepted exactly 1 cycle after IDLE is re-entered, and the frames are contiguous apart from ARM wait.
REQ-034 rst pulsed mid DATA bit 4: txd=1 next edge, tx_ready=1, and no further bits are emitted.
REQ-035 STOP_BITS=2, tx_data=0x00: txd low for 9 ticks, then high for 2 ticks before tx_ready=1.
REQ-036 UART_PARITY_EN, tx_data=0x07: parity bit=1 with PARITY_ODD=0 and 0 with PARITY_ODD=1, and the frame is 11 ticks.
REQ-037 baud_clk held static for 100 cycles after acceptance: the FSM stays in ARM and txd stays 1.
